// File: rtl/din_syn_shifter.sv
// din_syn_shifter: multi-channel serial loader with divided sclk and sync pulse; optional sdo readback under DIN_SYN_READBACK_EN
module din_syn_shifter #(
   parameter int DATA_W    = 491,
   parameter int N_CH      = 1,
   parameter int CLK_DIV   = 1,
   parameter int SYN_CYC   = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   trig,
   input  logic [N_CH*DATA_W-1:0] data_reg,
   input  logic                   clr_mode,
   input  logic                   clr_2_one,
`ifdef DIN_SYN_READBACK_EN
   input  logic [N_CH-1:0]        sdo,
   output logic [N_CH*DATA_W-1:0] rb_data,
   output logic                   rb_valid,
`endif
   output logic                   sclk,
   output logic [N_CH-1:0]        din,
   output logic                   syn,
   output logic                   out_en,
   output logic                   clk_out_en,
   output logic                   busy,
   output logic                   done
);
   localparam int PH_N = 2 * CLK_DIV;
   localparam int SY_N = SYN_CYC * PH_N;
   localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam int PW = PH_N > 1 ? $clog2(PH_N) : 1;
   localparam int SW = SY_N > 1 ? $clog2(SY_N) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(PH_N - 1);
   localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV);
   localparam logic [SW-1:0] SY_LAST  = SW'(SY_N - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, SYNC, DONE} state_t;

   state_t                         state_q, state_d;
   logic [BW-1:0]                  bit_q, bit_d;
   logic [PW-1:0]                  ph_q, ph_d;
   logic [SW-1:0]                  sy_q, sy_d;
   logic                           trig_prev_q, trig_prev_d;
   logic [N_CH-1:0][DATA_W-1:0]    sh_q, sh_d;
   logic                           start;

   assign start = state_q == IDLE && trig && !trig_prev_q;

   // sequencing: latch the word on start, walk bit periods, then sync, then one done cycle
   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      ph_d        = ph_q;
      sy_d        = sy_q;
      sh_d        = sh_q;
      trig_prev_d = trig;
      case (state_q)
         IDLE: if (start) begin
            state_d = SHIFT;
            bit_d   = '0;
            ph_d    = '0;
            sh_d    = clr_mode ? {(N_CH*DATA_W){clr_2_one}} : data_reg;
         end
         SHIFT: begin
            ph_d = ph_q == PH_LAST ? '0 : ph_q + 1'b1;
            if (ph_q == PH_LAST) begin
               for (int c = 0; c < N_CH; c++) sh_d[c] = MSB_FIRST != 0 ? sh_q[c] << 1 : sh_q[c] >> 1;
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = SYNC;
                  bit_d   = '0;
                  sy_d    = '0;
               end
            end
         end
         SYNC: begin
            sy_d    = sy_q + 1'b1;
            state_d = sy_q == SY_LAST ? DONE : SYNC;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and counter registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_q       <= '0;
         ph_q        <= '0;
         sy_q        <= '0;
         trig_prev_q <= 1'b0;
         sh_q        <= '0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         ph_q        <= ph_d;
         sy_q        <= sy_d;
         trig_prev_q <= trig_prev_d;
         sh_q        <= sh_d;
      end
   end

   // outputs decoded from registered state only, so they are glitch-free and low right after reset
   always_comb begin
      sclk       = state_q == SHIFT && ph_q >= PH_RISE;
      out_en     = state_q == SHIFT;
      clk_out_en = state_q == SHIFT;
      syn        = state_q == SYNC;
      busy       = state_q == SHIFT || state_q == SYNC;
      done       = state_q == DONE;
      din        = '0;
      for (int c = 0; c < N_CH; c++)
         din[c] = state_q == SHIFT && (MSB_FIRST != 0 ? sh_q[c][DATA_W-1] : sh_q[c][0]);
   end

`ifdef DIN_SYN_READBACK_EN
   logic [N_CH-1:0][DATA_W-1:0] cap_q, cap_d;
   logic [N_CH*DATA_W-1:0]      rb_data_q, rb_data_d;
   logic                        rb_valid_q, rb_valid_d;

   // capture sdo in the cycle sclk rises; publish the word as the transfer enters DONE
   always_comb begin
      cap_d      = cap_q;
      rb_data_d  = rb_data_q;
      rb_valid_d = start ? 1'b0 : rb_valid_q;
      if (state_q == SHIFT && ph_q == PH_RISE)
         for (int c = 0; c < N_CH; c++)
            cap_d[c] = MSB_FIRST != 0 ? (cap_q[c] << 1) | DATA_W'(sdo[c])
                                      : (cap_q[c] >> 1) | (DATA_W'(sdo[c]) << (DATA_W - 1));
      if (state_q == SYNC && sy_q == SY_LAST) begin
         rb_data_d  = cap_q;
         rb_valid_d = 1'b1;
      end
   end

   // readback registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cap_q      <= '0;
         rb_data_q  <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         cap_q      <= cap_d;
         rb_data_q  <= rb_data_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   assign rb_data  = rb_data_q;
   assign rb_valid = rb_valid_q;
`endif
endmodule

// File: tb/tb_din_syn_shifter.sv
// tb_din_syn_shifter: directed bench with a timeline model for two din_syn_shifter configurations
module tb_din_syn_shifter;
   localparam int WA = 8, NA = 2, CDA = 2, SA = 1, MA = 1;
   localparam int WB = 8, NB = 1, CDB = 1, SB = 2, MB = 0;
   localparam int TOT_A = (WA + SA) * 2 * CDA;
   localparam int TOT_B = (WB + SB) * 2 * CDB;

   logic clk = 0, rst = 1, trig_a = 0, trig_b = 0, clr_mode = 0, clr_2_one = 0;
   logic [15:0] data_a = '0;
   logic [7:0]  data_b = '0;
   logic sclk_a, syn_a, out_en_a, clk_out_en_a, busy_a, done_a;
   logic sclk_b, syn_b, out_en_b, clk_out_en_b, busy_b, done_b;
   logic [1:0] din_a;
   logic [0:0] din_b;
   int total = 0, bad = 0, cyc = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

`ifdef DIN_SYN_READBACK_EN
   logic [1:0] sdo_a = '0;
   logic [0:0] sdo_b = '0;
   logic [15:0] rb_data_a;
   logic [7:0]  rb_data_b;
   logic rb_valid_a, rb_valid_b;
   always @(posedge sclk_a) sdo_a <= din_a;
   always @(posedge sclk_b) sdo_b <= din_b;
`endif

   din_syn_shifter #(.DATA_W(WA), .N_CH(NA), .CLK_DIV(CDA), .SYN_CYC(SA), .MSB_FIRST(MA)) u_a (
      .clk_in(clk), .rst(rst), .trig(trig_a), .data_reg(data_a), .clr_mode(clr_mode), .clr_2_one(clr_2_one),
`ifdef DIN_SYN_READBACK_EN
      .sdo(sdo_a), .rb_data(rb_data_a), .rb_valid(rb_valid_a),
`endif
      .sclk(sclk_a), .din(din_a), .syn(syn_a), .out_en(out_en_a), .clk_out_en(clk_out_en_a),
      .busy(busy_a), .done(done_a));

   din_syn_shifter #(.DATA_W(WB), .N_CH(NB), .CLK_DIV(CDB), .SYN_CYC(SB), .MSB_FIRST(MB)) u_b (
      .clk_in(clk), .rst(rst), .trig(trig_b), .data_reg(data_b), .clr_mode(clr_mode), .clr_2_one(clr_2_one),
`ifdef DIN_SYN_READBACK_EN
      .sdo(sdo_b), .rb_data(rb_data_b), .rb_valid(rb_valid_b),
`endif
      .sclk(sclk_b), .din(din_b), .syn(syn_b), .out_en(out_en_b), .clk_out_en(clk_out_en_b),
      .busy(busy_b), .done(done_b));

   wire [7:0] pa = {done_a, busy_a, clk_out_en_a, out_en_a, syn_a, sclk_a, din_a};
   wire [7:0] pb = {done_b, busy_b, clk_out_en_b, out_en_b, syn_b, sclk_b, 1'b0, din_b};

   // model: per instance, cycles t=1.. since start; outputs follow from t by arithmetic
   logic        m_act [2];
   logic        m_tp  [2];
   int          m_t   [2];
   logic [15:0] m_w   [2];
   logic [1:0]  tg;
   logic [15:0] ld [2];
   assign tg = {trig_b, trig_a};
   always_comb begin
      ld[0] = clr_mode ? {16{clr_2_one}} : data_a;
      ld[1] = clr_mode ? {8'h0, {8{clr_2_one}}} : {8'h0, data_b};
   end

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_act[m] <= 0; m_tp[m] <= 0; m_t[m] <= 0;
         end else begin
            m_tp[m] <= tg[m];
            if (m_act[m]) begin
               if (m_t[m] == (m == 0 ? TOT_A : TOT_B) + 1) m_act[m] <= 0;
               else m_t[m] <= m_t[m] + 1;
            end else if (tg[m] && !m_tp[m]) begin
               m_act[m] <= 1; m_t[m] <= 1; m_w[m] <= ld[m];
            end
         end
      end
   end

   // {done,busy,clk_out_en,out_en,syn,sclk,din[1:0]}
   function automatic logic [7:0] mo(input int w, n, cd, s, msb, input logic a, input int t, input logic [15:0] wd);
      logic [7:0] r;
      int i, p, b;
      r = '0;
      if (a) begin
         if (t <= w * 2 * cd) begin
            i = (t - 1) / (2 * cd);
            p = (t - 1) % (2 * cd);
            b = msb != 0 ? w - 1 - i : i;
            r[6:4] = 3'b111;
            r[2] = p >= cd;
            for (int c = 0; c < n; c++) r[c] = wd[c*w+b];
         end else if (t <= (w + s) * 2 * cd) begin
            r[6] = 1; r[3] = 1;
         end else r[7] = 1;
      end
      return r;
   endfunction

   // every-cycle compare of both instances against the model
   always @(negedge clk) begin
      logic [7:0] ea, eb;
      if (chk_on) begin
         ea = mo(WA, NA, CDA, SA, MA, m_act[0], m_t[0], m_w[0]);
         eb = mo(WB, NB, CDB, SB, MB, m_act[1], m_t[1], m_w[1]);
         total += 2;
         if (pa !== ea) begin bad++; $display("FAIL cycle_a cyc=%0d got=%b want=%b", cyc, pa, ea); end
         if (pb !== eb) begin bad++; $display("FAIL cycle_b cyc=%0d got=%b want=%b", cyc, pb, eb); end
      end
   end

   // independent activity monitors used by the literal checks
   int e_a, syn_ca, busy_ca, done_ca, e_b, syn_cb, busy_cb, done_cb, last_b, per_b;
   logic [7:0] s0_a, s1_a, s_b;
   logic sclk_pa = 0, sclk_pb = 0;
   always @(negedge clk) begin
      if (busy_a) busy_ca++;
      if (syn_a) syn_ca++;
      if (done_a) done_ca++;
      if (sclk_a && !sclk_pa) begin e_a++; s0_a = {s0_a[6:0], din_a[0]}; s1_a = {s1_a[6:0], din_a[1]}; end
      if (busy_b) busy_cb++;
      if (syn_b) syn_cb++;
      if (done_b) done_cb++;
      if (sclk_b && !sclk_pb) begin e_b++; s_b = {s_b[6:0], din_b[0]}; per_b = cyc - last_b; last_b = cyc; end
      sclk_pa = sclk_a;
      sclk_pb = sclk_b;
   end

   task automatic clr_cnt();
      e_a = 0; syn_ca = 0; busy_ca = 0; done_ca = 0; s0_a = 0; s1_a = 0;
      e_b = 0; syn_cb = 0; busy_cb = 0; done_cb = 0; s_b = 0; per_b = 0; last_b = 0;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin bad++; $display("FAIL %s got=%0h want=%0h", nm, act, exp); end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_a();
      step(1); trig_a = 1; step(1); trig_a = 0;
   endtask

   task automatic wait_done(input bit b, input int lim);
      int i;
      for (i = 0; i < lim; i++) begin
         @(negedge clk);
         if (b ? done_b : done_a) break;
      end
      total++;
      if (i == lim) begin bad++; $display("FAIL timeout_%s got=%0d want<%0d", b ? "b" : "a", i, lim); end
   endtask

   initial begin
      step(2);
      chk_on = 1;
      chk("reset_a", pa, 0);
      chk("reset_b", pb, 0);
      step(1); rst = 0;

      clr_cnt(); data_a = 16'hA53C; pulse_a(); wait_done(0, 200);
`ifdef DIN_SYN_READBACK_EN
      chk("rb_valid_set", rb_valid_a, 1);
      chk("rb_data", rb_data_a, 16'hA53C);
`endif
      step(3);
      chk("basic_din0", s0_a, 8'h3C);
      chk("basic_din1", s1_a, 8'hA5);
      chk("basic_edges", e_a, 8);
      chk("basic_syn", syn_ca, 4);
      chk("basic_busy", busy_ca, 36);
      chk("basic_done", done_ca, 1);

      clr_cnt(); data_a = 16'h1234; clr_mode = 1; clr_2_one = 1; pulse_a();
`ifdef DIN_SYN_READBACK_EN
      chk("rb_valid_clr", rb_valid_a, 0);
`endif
      clr_mode = 0; wait_done(0, 200); step(2);
      chk("clr1_din0", s0_a, 8'hFF);
      chk("clr1_din1", s1_a, 8'hFF);
      clr_cnt(); data_a = 16'hFFFF; clr_mode = 1; clr_2_one = 0; pulse_a(); wait_done(0, 200); step(2);
      clr_mode = 0;
      chk("clr0_din0", s0_a, 8'h00);
      chk("clr0_din1", s1_a, 8'h00);

      clr_cnt(); data_b = 8'h01; step(1); trig_b = 1; step(1); trig_b = 0; wait_done(1, 200);
`ifdef DIN_SYN_READBACK_EN
      chk("rb_data_b", rb_data_b, 8'h01);
`endif
      step(2);
      chk("lsb_seq", s_b, 8'h80);
      chk("lsb_edges", e_b, 8);
      chk("lsb_period", per_b, 2);
      chk("lsb_busy", busy_cb, 20);
      chk("lsb_syn", syn_cb, 4);

      clr_cnt(); data_a = 16'h0F0F; step(1); trig_a = 1; step(100); trig_a = 0; step(5);
      chk("held_done", done_ca, 1);
      chk("held_edges", e_a, 8);

      clr_cnt(); data_a = 16'h0FF0; pulse_a(); step(10); data_a = 16'h1111; pulse_a(); step(60);
      chk("mid_done", done_ca, 1);
      chk("mid_din0", s0_a, 8'hF0);
      chk("mid_din1", s1_a, 8'h0F);

      clr_cnt(); data_a = 16'h0000; pulse_a(); step(13); rst = 1; step(1); rst = 0;
      chk("abort_outs", pa, 0);
`ifdef DIN_SYN_READBACK_EN
      chk("abort_rbv", rb_valid_a, 0);
`endif
      step(60);
      chk("abort_syn", syn_ca, 0);
      chk("abort_done", done_ca, 0);
      clr_cnt(); data_a = 16'h5AC3; pulse_a(); wait_done(0, 200); step(2);
      chk("after_din0", s0_a, 8'hC3);
      chk("after_din1", s1_a, 8'h5A);
      chk("after_done", done_ca, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/din_syn_shifter.md
Name: din_syn_shifter

Overview:
- Parametrised serial loader for on-chip shift-register chains.
- On a trigger it latches an N_CH-channel parallel word, either from the data input or a clear pattern.
- Shifts the word out on N_CH parallel data lines with a shared divided serial clock, then issues a sync (latch) pulse.
- Sits between the virtual-JTAG data buffer / virtual-key logic and the GPIO pins. Successor to the single-channel fixed-width DIN/CLK/SYNC driver.

Parameters:
- DATA_W, 491: bits per channel.
- N_CH, 1: number of parallel data channels sharing sclk/syn.
- CLK_DIV, 1: sclk half-period in clk_in cycles, ≥1.
- SYN_CYC, 1: syn high duration in sclk periods, ≥1.
- MSB_FIRST, 1: 1 = bit DATA_W-1 of each channel shifted first; 0 = bit 0 first.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- trig  input  1  start request; rising edge detected internally; synchronous to clk_in.
- data_reg  input  N_CH*DATA_W  payload; channel c occupies bits [c*DATA_W +: DATA_W].
- clr_mode  input  1  1 = send the clear pattern instead of data_reg.
- clr_2_one  input  1  clear-pattern value; all bits = clr_2_one.
- sclk  output  1  serial clock to the chain.
- din  output  N_CH  serial data, one bit per channel.
- syn  output  1  sync/latch pulse.
- out_en  output  1  high while din carries payload bits.
- clk_out_en  output  1  high while sclk is toggling.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset (rst=1 at an edge) forces outputs low next cycle: sclk, din, syn, out_en, clk_out_en, busy, done. It also sets state=IDLE and clears the counters and the trig edge register.
- Reset mid-transfer aborts immediately. There is no syn pulse and no done pulse.
- Start condition: trig=1 and trig_d=0 (trig_d is registered trig) while in IDLE.
  - Edges seen while busy are ignored and not queued.
  - A trig held high causes no restart.
- Load, on the start cycle k:
  - Shadow register = clr_mode ? {N_CH*DATA_W{clr_2_one}} : data_reg.
  - data_reg and clr_mode changes after cycle k do not affect the transfer.
- States: IDLE -> SHIFT -> SYNC -> DONE -> IDLE.
- SHIFT, entered at k+1:
  - busy=1, out_en=1, clk_out_en=1.
  - Bit i of each channel is driven on din during cycles k+1+2i*CLK_DIV … k+(2i+2)*CLK_DIV.
  - sclk is low for the first CLK_DIV cycles of each bit period, then high for CLK_DIV cycles. Data is therefore stable across each sclk rising edge.
  - Bit order follows MSB_FIRST.
  - The bit counter runs 0…DATA_W-1; after the last bit period, go to SYNC.
- SYNC:
  - sclk=0, din=0, out_en=0, clk_out_en=0.
  - syn=1 for SYN_CYC*2*CLK_DIV cycles.
- DONE:
  - One cycle with done=1, busy=0, syn=0.
  - Then IDLE. A trig edge sampled in the DONE cycle is ignored.
- Timing totals:
  - Busy duration = (DATA_W+SYN_CYC)*2*CLK_DIV cycles, from k+1 to k+(DATA_W+SYN_CYC)*2*CLK_DIV.
  - done is asserted in the next cycle.
- Idle levels: sclk=0, din=0, syn=0.
- Counter widths: $clog2 of DATA_W, of 2*CLK_DIV and of SYN_CYC*2*CLK_DIV, each sized ≥1 bit. No wrap occurs within a transfer.

Optional Feature:
- Macro DIN_SYN_READBACK_EN.
- When defined, the block adds:
  - input sdo [N_CH-1:0]: chain serial outputs.
  - output rb_data [N_CH*DATA_W-1:0]: captured data.
  - output rb_valid [1]: capture-valid flag.
- Capture rules:
  - sdo is sampled on the clk_in cycle of each sclk rising edge.
  - Samples are shifted into a capture register in the same bit order as transmission.
  - rb_data updates only at DONE.
  - rb_valid is set with done and cleared on the next start or on rst.
- rb_data resets to 0.
- When not defined, these ports and their logic are absent and the block behaves identically otherwise.

Test Plan:
- Basic shift: DATA_W=8, N_CH=2, CLK_DIV=2, MSB_FIRST=1; data_reg=16'hA5_3C, trig pulse.
  - din[0] sequence = 0,0,1,1,1,1,0,0 and din[1] sequence = 1,0,1,0,0,1,0,1, each sampled at sclk rising edges.
  - Exactly 8 sclk rising edges.
  - syn high 4 cycles.
  - busy high 36 cycles, then done for 1 cycle.
- Clear modes: clr_mode=1 with clr_2_one=1 gives all din bits 1; with clr_2_one=0 gives all 0. data_reg is ignored in both cases.
- LSB-first and divider: MSB_FIRST=0, CLK_DIV=1, data 8'h01 on channel 0.
  - First transmitted bit is 1, the rest 0.
  - sclk period is 2 cycles.
- Trigger robustness:
  - trig held high for 100 cycles → exactly one transfer.
  - A second trig edge mid-SHIFT → ignored.
  - data_reg changed mid-SHIFT → transmitted word unchanged.
- Reset mid-operation: rst asserted during bit 3 of SHIFT.
  - All outputs low next cycle; no syn, no done.
  - A new trig afterwards completes normally.
- Readback (DIN_SYN_READBACK_EN): sdo looped to din through one sclk-edge delay model.
  - rb_data equals the expected shifted word at done.
  - rb_valid is set with done and cleared on the next trig.
